// File: rtl/clk_div_pkg.sv
// Shared defaults, the channel configuration record and the channel-index width helper
// for the multi-channel clock/strobe divider.
package clk_div_pkg;

    localparam int NUM_CH_DEF      = 4;
    localparam int CNT_W_DEF       = 16;
    localparam int DEFAULT_DIV_DEF = 2;

    typedef struct packed {
        logic [CNT_W_DEF-1:0] div;
        logic [CNT_W_DEF-1:0] high;
    } clk_div_cfg_t;

    // A single channel still needs a 1-bit select so the port never collapses to zero width.
    function automatic int CHAN_IDX_W(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/clk_div_multi_if.sv
// Configuration write bus for clk_div_multi. A write transfers on a clock edge where
// cfg_valid and cfg_ready are both high; the master holds chan/div/high stable while valid.
interface clk_div_multi_if #(
    parameter int CHAN_W = 2,
    parameter int CNT_W  = 16
);
    logic              cfg_valid;
    logic              cfg_ready;
    logic [CHAN_W-1:0] cfg_chan;
    logic [CNT_W-1:0]  cfg_div;
    logic [CNT_W-1:0]  cfg_high;

    modport master (output cfg_valid, cfg_chan, cfg_div, cfg_high, input cfg_ready);
    modport slave  (input cfg_valid, cfg_chan, cfg_div, cfg_high, output cfg_ready);
endinterface

// File: rtl/clk_div_chan.sv
// One divider channel: phase counter, active and shadow configuration, pending flag
// and registered clk_out/tick outputs.
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             en,
    input  logic             sync,
    input  logic             wr,
    input  logic [CNT_W-1:0] wr_div,
    input  logic [CNT_W-1:0] wr_high,
    output logic             pending,
    output logic             clk_out,
    output logic             tick
);
    typedef struct packed {
        logic [CNT_W-1:0] div;
        logic [CNT_W-1:0] high;
    } cfg_t;

    localparam cfg_t RST_CFG = '{div: CNT_W'(DEFAULT_DIV), high: CNT_W'(DEFAULT_DIV / 2)};

    cfg_t             act;
    cfg_t             shd;
    cfg_t             eff;
    logic [CNT_W-1:0] cnt;
    logic             run;
    logic             last;

    always_comb begin
        run  = en && (act.div != '0);
        last = (cnt == act.div - CNT_W'(1));
        eff  = pending ? shd : act;
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            cnt     <= '0;
            act     <= RST_CFG;
            shd     <= '0;
            pending <= 1'b0;
            clk_out <= 1'b0;
            tick    <= 1'b0;
        end else begin
            if (!run) begin
                cnt     <= '0;
                clk_out <= 1'b0;
                tick    <= 1'b0;
                if (pending) begin
                    act     <= shd;
                    pending <= 1'b0;
                end
            end else if (sync) begin
                // Realign uses the freshly applied config for this phase-0 pass.
                act     <= eff;
                pending <= 1'b0;
                if (eff.div == '0) begin
                    cnt     <= '0;
                    clk_out <= 1'b0;
                    tick    <= 1'b0;
                end else begin
                    cnt     <= (eff.div == CNT_W'(1)) ? '0 : CNT_W'(1);
                    clk_out <= (eff.high != '0);
                    tick    <= 1'b1;
                end
            end else begin
                tick    <= (cnt == '0);
                clk_out <= (cnt < act.high);
                cnt     <= last ? '0 : cnt + CNT_W'(1);
                if (last && pending) begin
                    act     <= shd;
                    pending <= 1'b0;
                end
            end
            // A write is only accepted with pending clear, so it always lands after any apply above.
            if (wr) begin
                shd     <= '{div: wr_div, high: wr_high};
                pending <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/clk_div_multi.sv
// N-channel programmable clock/strobe divider: channel array plus configuration
// write decode and per-channel ready mux.
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int NUM_CH      = NUM_CH_DEF,
    parameter int CNT_W       = CNT_W_DEF,
    parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic [NUM_CH-1:0] en,
    input  logic              sync,
    clk_div_multi_if.slave    cfg,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick
);
    localparam int CHAN_W = CHAN_IDX_W(NUM_CH);

    logic [NUM_CH-1:0] pending;
    logic [NUM_CH-1:0] wr;

    // Out-of-range channel indices report ready and the write is dropped.
    always_comb begin
        cfg.cfg_ready = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cfg.cfg_chan == CHAN_W'(i)) cfg.cfg_ready = !pending[i];
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign wr[i] = cfg.cfg_valid && cfg.cfg_ready && (cfg.cfg_chan == CHAN_W'(i));

        clk_div_chan #(
            .CNT_W       (CNT_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_chan (
            .clk_in  (clk_in),
            .rst     (rst),
            .en      (en[i]),
            .sync    (sync),
            .wr      (wr[i]),
            .wr_div  (cfg.cfg_div),
            .wr_high (cfg.cfg_high),
            .pending (pending[i]),
            .clk_out (clk_out[i]),
            .tick    (tick[i])
        );
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// Bench for clk_div_multi: directed scenarios plus a randomized stretch, checked each
// cycle against a phase/queue reference model of the divider behaviour.
module tb_clk_div_multi;
    import clk_div_pkg::*;

    localparam int NUM_CH      = 4;
    localparam int CNT_W       = 16;
    localparam int DEFAULT_DIV = 2;
    localparam int CHAN_W      = 2;

    logic              clk_in = 1'b0;
    logic              rst;
    logic [NUM_CH-1:0] en;
    logic              sync;
    logic [NUM_CH-1:0] clk_out;
    logic [NUM_CH-1:0] tick;

    clk_div_multi_if #(.CHAN_W(CHAN_W), .CNT_W(CNT_W)) cfg_bus ();

    clk_div_multi #(
        .NUM_CH      (NUM_CH),
        .CNT_W       (CNT_W),
        .DEFAULT_DIV (DEFAULT_DIV)
    ) dut (
        .clk_in  (clk_in),
        .rst     (rst),
        .en      (en),
        .sync    (sync),
        .cfg     (cfg_bus.slave),
        .clk_out (clk_out),
        .tick    (tick)
    );

    always #5 clk_in = ~clk_in;

    int errors = 0;
    int checks = 0;

    // Reference model: current phase and config per channel, queued pending writes.
    int                m_div  [NUM_CH];
    int                m_high [NUM_CH];
    int                m_cnt  [NUM_CH];
    clk_div_cfg_t      sh_q   [NUM_CH][$];
    logic [NUM_CH-1:0] e_tick = '0;
    logic [NUM_CH-1:0] e_clk  = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void apply_pending(input int i);
        clk_div_cfg_t c;
        if (sh_q[i].size() != 0) begin
            c = sh_q[i].pop_front();
            m_div[i]  = int'(c.div);
            m_high[i] = int'(c.high);
        end
    endfunction

    function automatic void model_edge(input bit acc);
        int p;
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                m_div[i]  = DEFAULT_DIV;
                m_high[i] = DEFAULT_DIV / 2;
                m_cnt[i]  = 0;
                sh_q[i].delete();
            end
            e_tick = '0;
            e_clk  = '0;
            return;
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (!en[i] || m_div[i] == 0) begin
                apply_pending(i);
                m_cnt[i]  = 0;
                e_tick[i] = 1'b0;
                e_clk[i]  = 1'b0;
            end else begin
                if (sync) begin
                    apply_pending(i);
                    m_cnt[i] = 0;
                end
                if (m_div[i] == 0) begin
                    m_cnt[i]  = 0;
                    e_tick[i] = 1'b0;
                    e_clk[i]  = 1'b0;
                end else begin
                    p         = m_cnt[i];
                    e_tick[i] = (p == 0);
                    e_clk[i]  = (p < m_high[i]);
                    m_cnt[i]  = (p + 1) % m_div[i];
                    if (!sync && m_cnt[i] == 0) apply_pending(i);
                end
            end
        end
        if (acc && int'(cfg_bus.cfg_chan) < NUM_CH)
            sh_q[int'(cfg_bus.cfg_chan)].push_back('{div: cfg_bus.cfg_div, high: cfg_bus.cfg_high});
    endfunction

    // One clock: check ready on the settled inputs, advance the model, compare outputs after the edge.
    task automatic cycle();
        bit exp_ready;
        int ch;
        ch        = int'(cfg_bus.cfg_chan);
        exp_ready = (ch < NUM_CH) ? (sh_q[ch].size() == 0) : 1'b1;
        if (!rst) chk("cfg_ready", cfg_bus.cfg_ready, exp_ready);
        model_edge(cfg_bus.cfg_valid && exp_ready);
        @(posedge clk_in);
        #1;
        chk("tick", tick, e_tick);
        chk("clk_out", clk_out, e_clk);
    endtask

    task automatic wr_cfg(input int ch, input int d, input int h);
        cfg_bus.cfg_valid = 1'b1;
        cfg_bus.cfg_chan  = CHAN_W'(ch);
        cfg_bus.cfg_div   = CNT_W'(d);
        cfg_bus.cfg_high  = CNT_W'(h);
        cycle();
        cfg_bus.cfg_valid = 1'b0;
    endtask

    initial begin
        logic [3:0]        pat0;
        logic [9:0]        pat1;
        logic [5:0]        pat6;
        logic              or_clk0, and_clk1, and_tick2, or_ch3;

        rst               = 1'b1;
        en                = '0;
        sync              = 1'b0;
        cfg_bus.cfg_valid = 1'b0;
        cfg_bus.cfg_chan  = '0;
        cfg_bus.cfg_div   = '0;
        cfg_bus.cfg_high  = '0;

        // Reset state
        cycle();
        cycle();
        chk("reset_ready", cfg_bus.cfg_ready, 1'b1);
        rst = 1'b0;

        // Channel 0 at default div=2, high=1
        en = 4'b0001;
        for (int k = 0; k < 4; k++) begin
            cycle();
            if (k == 0) chk("ch0_first_tick", tick[0], 1'b1);
            pat0[3-k] = clk_out[0];
        end
        chk("ch0_pattern", pat0, 4'b1010);

        // Channel 1 div=5 high=2
        wr_cfg(1, 5, 2);
        cycle();
        en = 4'b0011;
        for (int k = 0; k < 10; k++) begin
            cycle();
            if (k == 0) chk("ch1_first_tick", tick[1], 1'b1);
            pat1[9-k] = clk_out[1];
        end
        chk("ch1_div5_pattern", pat1, 10'b1100011000);

        // Mid-period reconfiguration, second write stalls
        cycle();
        cycle();
        wr_cfg(1, 3, 1);
        cfg_bus.cfg_valid = 1'b1;
        cfg_bus.cfg_div   = CNT_W'(4);
        cfg_bus.cfg_high  = CNT_W'(2);
        chk("busy_ready", cfg_bus.cfg_ready, 1'b0);
        cycle();
        cfg_bus.cfg_valid = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (k == 0) begin
                cfg_bus.cfg_valid = 1'b1;
                cfg_bus.cfg_chan  = CHAN_W'(2);
                cfg_bus.cfg_div   = CNT_W'(6);
                cfg_bus.cfg_high  = CNT_W'(3);
                chk("other_chan_ready", cfg_bus.cfg_ready, 1'b1);
            end
            cycle();
            cfg_bus.cfg_valid = 1'b0;
            pat1[9-k] = clk_out[1];
        end
        chk("ch1_reconfig_pattern", pat1, 10'b0100100100);

        // Duty and divide edge cases
        en = '0;
        cycle();
        wr_cfg(0, 4, 0);
        wr_cfg(1, 3, 7);
        wr_cfg(2, 1, 1);
        wr_cfg(3, 0, 0);
        cycle();
        en        = 4'b1111;
        or_clk0   = 1'b0;
        and_clk1  = 1'b1;
        and_tick2 = 1'b1;
        or_ch3    = 1'b0;
        for (int k = 0; k < 8; k++) begin
            cycle();
            or_clk0   = or_clk0 | clk_out[0];
            and_clk1  = and_clk1 & clk_out[1];
            and_tick2 = and_tick2 & tick[2];
            or_ch3    = or_ch3 | tick[3] | clk_out[3];
        end
        chk("high0_low", or_clk0, 1'b0);
        chk("high_ge_div_high", and_clk1, 1'b1);
        chk("div1_tick_stuck", and_tick2, 1'b1);
        chk("div0_stopped", or_ch3, 1'b0);

        // Randomized traffic
        for (int k = 0; k < 150; k++) begin
            if ($urandom_range(0, 9) == 0) en = NUM_CH'($urandom_range(0, 15));
            sync              = ($urandom_range(0, 7) == 0);
            cfg_bus.cfg_valid = ($urandom_range(0, 2) == 0);
            cfg_bus.cfg_chan  = CHAN_W'($urandom_range(0, NUM_CH - 1));
            cfg_bus.cfg_div   = CNT_W'($urandom_range(0, 7));
            cfg_bus.cfg_high  = CNT_W'($urandom_range(0, 8));
            cycle();
        end
        sync              = 1'b0;
        cfg_bus.cfg_valid = 1'b0;

        // Sync realignment with a pending write on channel 0
        en = '0;
        cycle();
        for (int i = 0; i < NUM_CH; i++) wr_cfg(i, $urandom_range(2, 7), $urandom_range(0, 8));
        cycle();
        en = 4'b0111;
        repeat ($urandom_range(3, 12)) cycle();
        wr_cfg(0, 3, 2);
        sync = 1'b1;
        cycle();
        sync = 1'b0;
        chk("sync_ticks", tick, 4'b0111);
        pat6[5] = clk_out[0];
        for (int k = 1; k < 6; k++) begin
            cycle();
            pat6[5-k] = clk_out[0];
        end
        chk("sync_applied_cfg", pat6, 6'b110110);

        // Reset with a pending config
        en = 4'b0001;
        wr_cfg(0, 40, 20);
        rst = 1'b1;
        cycle();
        chk("rst_ready", cfg_bus.cfg_ready, 1'b1);
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            cycle();
            pat6[5-k] = clk_out[0];
        end
        chk("post_rst_default_div", pat6, 6'b101010);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
